// File: rtl/alu_seq16.sv
// alu_seq16: sequences 16-bit ADD/SUB/XOR/AND through an 8-bit ALU, low byte first
module alu_seq16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [2:0]  alu_cmd,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_sc_i,
   input  logic [7:0]  alu_rslt,
   input  logic        alu_sc_o,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_carry,
   output logic        rsp_zero,
   output logic        rsp_pari
);
   typedef enum logic [1:0] {IDLE, LO, HI, RSP} state_t;
   state_t state, state_nxt;
   logic [1:0]  op;
   logic [15:0] a_q, b_q, data;
   logic [7:0]  lo_q, a_byte, b_byte;
   logic        chain_q, carry, arith, sub, busy;
   assign arith = ~op[1];
   assign sub = (op == 2'b01);
   assign busy = (state == LO) || (state == HI);
   assign a_byte = (state == HI) ? a_q[15:8] : a_q[7:0];
   assign b_byte = (state == HI) ? b_q[15:8] : b_q[7:0];
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // next state plus Moore request/ALU/response-valid outputs
   always_comb begin
      state_nxt = state == IDLE ? (req_valid ? LO : IDLE) :
                  state == LO   ? HI :
                  state == HI   ? RSP :
                                  (rsp_ready ? IDLE : RSP);
      req_ready = (state == IDLE);
      rsp_valid = (state == RSP);
      alu_cmd = busy ? (arith ? 3'b000 : {1'b1, op[0], 1'b0}) : 3'b000;
      alu_a = busy ? a_byte : 8'h00;
      alu_b = busy ? (sub ? ~b_byte : b_byte) : 8'h00;
      alu_sc_i = (state == LO) ? sub : (state == HI) ? (arith & chain_q) : 1'b0;
   end
   // request capture and byte-wise result assembly; response only updates entering RSP
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op <= 2'b00;
         a_q <= 16'h0;
         b_q <= 16'h0;
         lo_q <= 8'h0;
         chain_q <= 1'b0;
         data <= 16'h0;
         carry <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            op <= req_op;
            a_q <= req_a;
            b_q <= req_b;
         end
         if (state == LO) begin
            lo_q <= alu_rslt;
            chain_q <= alu_sc_o;
         end
         if (state == HI) begin
            data <= {alu_rslt, lo_q};
            carry <= arith & alu_sc_o;
         end
      end
   assign rsp_data = data;
   assign rsp_carry = carry;
   assign rsp_zero = ~|data;
   assign rsp_pari = ^data;
endmodule
